// File: rtl/key_scan_debounce.sv
// key_scan_debounce: synchronises four active-low push-buttons, debounces the
// pressed pattern, and emits a one-cycle key_flag with a held active-high
// key_value. While the pattern is held, optional auto-repeat re-issues the flag.
module key_scan_debounce #(
  parameter int KEY_W           = 4,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_data,
  output logic             key_flag,
  output logic [KEY_W-1:0] key_value
);

  // The counter is shared by every timed state, so size it for the longest interval.
  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CNT_W  = $clog2(MAX_C);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    HOLD     = 3'd2,
    REPEAT   = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] sync1_q, sync1_d;
  logic [KEY_W-1:0] sync2_q, sync2_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] key_value_q, key_value_d;
  logic             key_flag_q, key_flag_d;
  logic [KEY_W-1:0] pressed;

  // Next-state, counter and output strobe logic for the scan FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_value_d = key_value_q;
    key_flag_d  = 1'b0;
    sync1_d     = key_data;
    sync2_d     = sync1_q;
    pressed     = ~sync2_q;

    case (state_q)
      IDLE: begin
        if (pressed != '0) begin
          cand_d  = pressed;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        // Any change of the pattern abandons this attempt silently.
        if (pressed != cand_q) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          key_value_d = cand_q;
          key_flag_d  = 1'b1;
          cnt_d       = '0;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (pressed != key_value_q) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end else if ((REPEAT_EN != 0) && (cnt_q == RD_LAST)) begin
          key_flag_d = 1'b1;
          cnt_d      = '0;
          state_d    = REPEAT;
        end else if (cnt_q != CNT_MAX) begin
          // Saturate so a long hold without repeat never wraps.
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      REPEAT: begin
        if (pressed != key_value_q) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (cnt_q == RP_LAST) begin
          key_flag_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RELEASE: begin
        // All keys must stay released for a full window before a new press counts.
        if (pressed != '0) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, synchroniser and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sync1_q     <= '1;
      sync2_q     <= '1;
      cand_q      <= '0;
      key_value_q <= '0;
      key_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cand_q      <= cand_d;
      key_value_q <= key_value_d;
      key_flag_q  <= key_flag_d;
    end
  end

  assign key_flag  = key_flag_q;
  assign key_value = key_value_q;

endmodule

// File: doc/key_scan_debounce.md
Name: key_scan_debounce

Overview:
- Producer side of the key_flag/key_value interface consumed by the mode/threshold selection logic.
- Samples four raw active-low push-buttons and synchronises and debounces them.
- Emits a one-cycle key_flag with a stable active-high key pattern on key_value.
- Optional auto-repeat while a key pattern is held, so downstream increment/decrement logic steps continuously.

Parameters:
- KEY_W, 4: number of keys.
- DEBOUNCE_CYCLES, 2000000: stable cycles required for press and for release (20 ms at 100 MHz). Minimum 2.
- REPEAT_EN, 1: 1 enables auto-repeat, 0 disables it.
- REPEAT_DELAY, 50000000: hold cycles after the first flag before the first repeat flag. Minimum 2.
- REPEAT_PERIOD, 15000000: cycles between subsequent repeat flags. Minimum 2.

Ports:
- clk  input  1  system clock, 100 MHz. Single clock domain.
- rst_n  input  1  reset, synchronous, active-low.
- key_data  input  KEY_W  raw buttons, active-low (0 = pressed), asynchronous to clk.
- key_flag  output  1  one-cycle strobe: key_value is valid and newly reported.
- key_value  output  KEY_W  active-high pressed pattern (bit i = key i pressed). Held between flags.

Behaviour:
- Reset: synchronous, active-low, applies at every rising edge with rst_n=0.
  - key_flag=0, key_value=0, state=IDLE, cnt=0.
  - Synchroniser flops reset to all-ones (released).
- Synchroniser: two flops on key_data; p = ~sync2 (active-high pressed vector).
- cnt width: $clog2 of the largest of the three cycle parameters.
- IDLE: if p!=0, cand<=p, cnt<=0, go to DEBOUNCE.
- DEBOUNCE:
  - If p!=cand, return to IDLE and emit nothing.
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1: key_value<=cand, key_flag<=1, cnt<=0, go to HOLD.
  - Otherwise cnt<=cnt+1.
- HOLD:
  - If p!=key_value (release, partial release or extra key), cnt<=0 and go to RELEASE.
  - Otherwise, if REPEAT_EN and cnt==REPEAT_DELAY-1: key_flag<=1, cnt<=0, go to REPEAT.
  - Otherwise cnt<=cnt+1. The counter saturates when REPEAT_EN=0.
- REPEAT:
  - Same exit check as HOLD.
  - If cnt==REPEAT_PERIOD-1: key_flag<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- RELEASE:
  - If p!=0, cnt<=0.
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to IDLE.
  - Otherwise cnt<=cnt+1.
  - No flag is produced in this state.
  - A new press is accepted only after returning to IDLE.
- key_flag is high for exactly one cycle per event and is never high on consecutive cycles.
- key_value changes only in the cycle key_flag rises, and is retained after release.
- Latency: edge 0 is the first edge sampling key_data with the key held stable.
  - First key_flag is high in the cycle after edge DEBOUNCE_CYCLES+2.
  - First repeat flag follows edge DEBOUNCE_CYCLES+2+REPEAT_DELAY.
  - Later repeat flags come every REPEAT_PERIOD edges.
- Simultaneous keys: a multi-key pattern stable for the debounce window is reported as-is (e.g. 4'b1100). Any pattern change during debounce restarts from IDLE.
- Reset mid-operation: any in-progress debounce or repeat is abandoned. A key held through reset is re-debounced from release of reset, with latency measured from the first edge with rst_n=1.

Test Plan (DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=16):
1. REPEAT_EN=0; key_data=4'b0111 from edge 0, held 200 cycles, then released.
   - Exactly one key_flag, after edge 10, with key_value=4'b1000.
   - No further flags; key_value stays 4'b1000 after release.
2. key_data toggles 4'b1011/4'b1111 every 3 cycles for 30 cycles, then stays 4'b1011.
   - One key_flag, 10 edges after the last transition, key_value=4'b0100.
   - No flag during bouncing.
3. REPEAT_EN=1; 4'b0111 held 120 cycles from edge 0.
   - key_flag after edges 10, 50, 66, 82, 98, 114, with key_value=4'b1000 each time.
   - Flags stop on release.
4. After a debounced press, release, glitch low for 3 cycles 4 cycles into release debounce, then stay released; press again.
   - No flag from the glitch.
   - The new press flags only after RELEASE completes and full debounce elapses.
5. 4'b0011 applied together → one flag, key_value=4'b1100.
   - Separately: hold 4'b1110, then add key 1 (4'b1100) → no new flag until all keys are released and a fresh press debounces.
6. Key held; rst_n=0 at edge 6 for 2 cycles.
   - No flag; key_flag=0 and key_value=0 during reset.
   - key_flag after edge 10 counted from the first edge with rst_n=1.
